// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute instruction sequencer; optional single-step via SEQ_SINGLE_STEP_EN
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic [15:0] ir,
    output logic        dec_cs,
    input  logic        extended_cycle,
    output logic [15:0] ext_word,
    output logic        exec_start,
    input  logic        exec_done,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic        branch_taken,
    input  logic [15:0] new_pc,
    output logic [15:0] pc,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        FETCH_EXT = 3'd2,
        EXECUTE   = 3'd3,
        STEP_WAIT = 3'd4
    } seq_state_t;

    localparam logic [15:0] PC_INC = 16'(PC_STEP);

    seq_state_t cur_state;
    seq_state_t nxt_state;
    logic       exec_first;

    assign state    = cur_state;
    assign mem_addr = pc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state decode and per-state control strobes; reset gates the strobes immediately
    always_comb begin
        nxt_state  = cur_state;
        mem_rd     = 1'b0;
        dec_cs     = 1'b0;
        exec_start = 1'b0;
        case (cur_state)
            FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) nxt_state = DECODE;
            end
            DECODE: begin
                dec_cs    = 1'b1;
                nxt_state = extended_cycle ? FETCH_EXT : EXECUTE;
            end
            FETCH_EXT: begin
                mem_rd = 1'b1;
                if (mem_ready) nxt_state = EXECUTE;
            end
            EXECUTE: begin
                exec_start = exec_first;
                if (exec_done) begin
`ifdef SEQ_SINGLE_STEP_EN
                    nxt_state = STEP_WAIT;
`else
                    nxt_state = FETCH;
`endif
                end
            end
            STEP_WAIT: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (step) nxt_state = FETCH;
`else
                nxt_state = FETCH;
`endif
            end
            default: nxt_state = FETCH;
        endcase
        if (rst) begin
            mem_rd     = 1'b0;
            dec_cs     = 1'b0;
            exec_start = 1'b0;
        end
    end

    // Marks the first EXECUTE cycle so exec_start fires once per instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_first <= 1'b0;
        end else begin
            exec_first <= (nxt_state == EXECUTE) && (cur_state != EXECUTE);
        end
    end

    // Datapath: instruction/extension latches and program counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            ext_word <= 16'h0000;
        end else begin
            case (cur_state)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_data;
                        pc <= pc + PC_INC;
                    end
                end
                FETCH_EXT: begin
                    if (mem_ready) begin
                        ext_word <= mem_data;
                        pc       <= pc + PC_INC;
                    end
                end
                EXECUTE: begin
                    if (exec_done && branch_taken) begin
                        pc <= {new_pc[15:1], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed vector bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [15:0] ir;
    logic        dec_cs;
    logic        extended_cycle;
    logic [15:0] ext_word;
    logic        exec_start;
    logic        exec_done;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif
    logic        branch_taken;
    logic [15:0] new_pc;
    logic [15:0] pc;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ready(mem_ready), .ir(ir), .dec_cs(dec_cs),
        .extended_cycle(extended_cycle), .ext_word(ext_word),
        .exec_start(exec_start), .exec_done(exec_done),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .branch_taken(branch_taken), .new_pc(new_pc), .pc(pc), .state(state)
    );

    typedef struct {
        logic        rdy;
        logic [15:0] data;
        logic        ext;
        logic        done;
        logic        br;
        logic [15:0] npc;
        logic [2:0]  e_state;
        logic        e_rd;
        logic        e_dec;
        logic        e_start;
        logic [15:0] e_pc;
        logic [15:0] e_ir;
        logic [15:0] e_ext;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_ready = 1'b0; mem_data = 16'h0000; extended_cycle = 1'b0;
        exec_done = 1'b0; branch_taken = 1'b0; new_pc = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        // reset state before any clock edge
        #1;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_ext", ext_word, 16'h0000);
        chk("rst_mem_rd", 16'(mem_rd), 16'd0);
        chk("rst_dec_cs", 16'(dec_cs), 16'd0);
        chk("rst_exec_start", 16'(exec_start), 16'd0);

`ifndef SEQ_SINGLE_STEP_EN
        //            rdy data     ext done br npc      st   rd  dec start pc        ir        ext
        tbl[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h1234, 16'h0000};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 16'h0000};
        tbl[3]  = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 16'h0000};
        tbl[4]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h1234, 16'hBEEF};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0101, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h1234, 16'hBEEF};
        tbl[6]  = '{1'b1, 16'h0ABC, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h1234, 16'hBEEF};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0, 16'h0102, 16'h0ABC, 16'hBEEF};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 16'h0102, 16'h0ABC, 16'hBEEF};
        tbl[9]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0102, 16'h0ABC, 16'hBEEF};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0, 16'h0104, 16'h1111, 16'hBEEF};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 3'd3, 1'b0, 1'b0, 1'b1, 16'h0104, 16'h1111, 16'hBEEF};
        for (int i = 12; i <= 16; i++)
            tbl[i] = '{1'b0, 16'h7777, 1'b0, 1'b1, 1'b1, 16'h0200, 3'd0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h1111, 16'hBEEF};
        tbl[17] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h1111, 16'hBEEF};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h2222, 16'hBEEF};

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            mem_ready = tbl[i].rdy; mem_data = tbl[i].data; extended_cycle = tbl[i].ext;
            exec_done = tbl[i].done; branch_taken = tbl[i].br; new_pc = tbl[i].npc;
            #1;
            chk($sformatf("v%0d_state", i), 16'(state), 16'(tbl[i].e_state));
            chk($sformatf("v%0d_mem_rd", i), 16'(mem_rd), 16'(tbl[i].e_rd));
            chk($sformatf("v%0d_dec_cs", i), 16'(dec_cs), 16'(tbl[i].e_dec));
            chk($sformatf("v%0d_exec_start", i), 16'(exec_start), 16'(tbl[i].e_start));
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_ir", i), ir, tbl[i].e_ir);
            chk($sformatf("v%0d_ext_word", i), ext_word, tbl[i].e_ext);
            if (tbl[i].e_rd) chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_pc);
        end

        // back-to-back one-cycle instructions: fetches at 0,2,4 every third cycle
        idle_inputs();
        do_reset();
        mem_ready = 1'b1; mem_data = 16'h1234; exec_done = 1'b1;
        begin
            logic [15:0] addrs[3];
            int          cyc[3];
            int          nf = 0;
            for (int c = 0; c < 9; c++) begin
                #1;
                if (mem_rd && nf < 3) begin
                    addrs[nf] = mem_addr;
                    cyc[nf]   = c;
                    nf++;
                end
                @(negedge clk);
            end
            chk("tp_fetch_count", 16'(nf), 16'd3);
            for (int k = 0; k < 3 && k < nf; k++) begin
                chk($sformatf("tp_addr%0d", k), addrs[k], 16'(2 * k));
                chk($sformatf("tp_cycle%0d", k), 16'(cyc[k]), 16'(3 * k));
            end
        end
`endif

        // reset pulsed during EXECUTE with exec_done low
        idle_inputs();
        do_reset();
        mem_ready = 1'b1; mem_data = 16'h4321;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rx_in_execute", 16'(state), 16'd3);
        rst = 1'b1;
        #1;
        chk("rx_state", 16'(state), 16'd0);
        chk("rx_mem_rd", 16'(mem_rd), 16'd0);
        chk("rx_exec_start", 16'(exec_start), 16'd0);
        chk("rx_pc", pc, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rx_refetch_rd", 16'(mem_rd), 16'd1);
        chk("rx_refetch_addr", mem_addr, 16'h0000);

        // reset asserted mid-read must drop mem_rd at once
        rst = 1'b1;
        #1;
        chk("rf_mem_rd", 16'(mem_rd), 16'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef SEQ_SINGLE_STEP_EN
        // single-step: park in STEP_WAIT, then one pulse lets one instruction through
        idle_inputs();
        do_reset();
        step = 1'b0; mem_ready = 1'b1; mem_data = 16'h1234; exec_done = 1'b1;
        begin
            int starts = 0;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (exec_start) starts++;
                @(negedge clk);
            end
            #1;
            chk("ss_park_state", 16'(state), 16'd4);
            chk("ss_first_starts", 16'(starts), 16'd1);
            chk("ss_park_rd", 16'(mem_rd), 16'd0);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            starts = 0;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (exec_start) starts++;
                @(negedge clk);
            end
            #1;
            chk("ss_step_starts", 16'(starts), 16'd1);
            chk("ss_step_state", 16'(state), 16'd4);
            chk("ss_step_pc", pc, 16'h0004);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 2, byte increment per fetched word.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mem_rd  output  1  memory read request.
REQ-006 SHALL have port mem_addr  output  16  read address, equal to pc while mem_rd=1.
REQ-007 SHALL have port mem_data  input  16  read data, valid when mem_ready=1.
REQ-008 SHALL have port mem_ready  input  1  read completion strobe.
REQ-009 SHALL have port ir  output  16  latched instruction word, drives decoder word.
REQ-010 SHALL have port dec_cs  output  1  decoder select.
REQ-011 SHALL have port extended_cycle  input  1  from decoder; second word needed.
REQ-012 SHALL have port ext_word  output  16  latched second (extended) word.
REQ-013 SHALL have port exec_start  output  1  one-cycle execute strobe.
REQ-014 SHALL have port exec_done  input  1  execute unit completion strobe.
REQ-015 SHALL have port branch_taken  input  1  sampled with exec_done; load new_pc.
REQ-016 SHALL have port new_pc  input  16  branch target from decoder.
REQ-017 SHALL have port pc  output  16  current program counter, drives decoder pc.
REQ-018 SHALL have port state  output  3  FSM state encoding, debug.

Function
REQ-019 SHALL implement states FETCH=0, DECODE=1, FETCH_EXT=2, EXECUTE=3, STEP_WAIT=4.
REQ-020 FETCH: mem_rd=1, mem_addr=pc; on mem_ready=1 latch ir<=mem_data, pc<=pc+PC_STEP, go DECODE; otherwise hold.
REQ-021 mem_ready asserted in the first FETCH cycle SHALL complete the fetch in that cycle (one-cycle minimum).
REQ-022 DECODE: dec_cs=1 for exactly one cycle; if extended_cycle=1 go FETCH_EXT, else go EXECUTE.
REQ-023 FETCH_EXT: as FETCH but latch ext_word<=mem_data; ir SHALL remain unchanged; then go EXECUTE.
REQ-024 EXECUTE: exec_start=1 only in the first EXECUTE cycle; wait for exec_done.
REQ-025 exec_done in the same cycle as exec_start SHALL be accepted (one-cycle execute).
REQ-026 On exec_done: if branch_taken=1 pc<=new_pc, else pc unchanged; go FETCH (or STEP_WAIT per REQ-034).
REQ-027 pc arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 = 16'h0000, no flag.
REQ-028 mem_rd SHALL be 0 in DECODE, EXECUTE and STEP_WAIT; dec_cs SHALL be 0 outside DECODE.
REQ-029 exec_done or mem_ready arriving in a state not waiting for it SHALL be ignored.
REQ-030 Bit 0 of new_pc SHALL be cleared when loaded (word alignment).

Reset
REQ-031 rst=1 SHALL immediately force state=FETCH, pc=RESET_PC, ir=0, ext_word=0, mem_rd=0 (combinationally gated), dec_cs=0, exec_start=0.
REQ-032 Reset mid-read or mid-execute SHALL abandon the operation; the first fetch after rst release SHALL read RESET_PC.

Configuration
REQ-033 Macro SEQ_SINGLE_STEP_EN SHALL, when defined, add input step (1 bit) after exec_done in the port list.
REQ-034 With SEQ_SINGLE_STEP_EN: on exec_done go STEP_WAIT; leave to FETCH on the cycle step=1; step held high SHALL advance one instruction per pass through STEP_WAIT.
REQ-035 Without SEQ_SINGLE_STEP_EN: no step port, STEP_WAIT unreachable, exec_done goes directly to FETCH.

Verification
REQ-036 Reset, mem_ready tied 1, mem_data=16'h1234, extended_cycle=0, exec_done=1 -> mem_addr 0000,0002,0004 on successive fetches; one instruction per 3 cycles.
REQ-037 extended_cycle=1 in DECODE, second read returns 16'hBEEF -> ext_word=BEEF, ir unchanged, pc advanced by 4 total, exec_start once.
REQ-038 branch_taken=1, new_pc=16'h0101 with exec_done -> next mem_addr=16'h0100.
REQ-039 pc=16'hFFFE fetch -> pc becomes 16'h0000; mem_ready delayed 5 cycles -> mem_rd held 5 cycles, ir stable.
REQ-040 rst pulsed during EXECUTE with exec_done low -> mem_rd=0 and state=FETCH same cycle; next fetch at RESET_PC.
REQ-041 SEQ_SINGLE_STEP_EN defined, step=0 -> sequencer parks in STEP_WAIT; one-cycle step pulse -> exactly one further instruction executes.
